addr_scanner: RTL and testbench

- Parametrised successor to the display address sweeper. Generates a wrapping address sequence over a programmable window [lo, hi] for selecting RF/DM/ALU words on the 7-segment display.
- Uses a clock-enable prescaler; no derived clocks. Supports run, hold and single-step modes, up/down direction, and a fast/slow rate.
- Sits in the top level between the switch inputs and the debug-read ports of SCPU and dm.

---
 rtl/addr_scanner_pkg.sv | 31 +++
 rtl/addr_scanner_tick_gen.sv | 44 ++++
 rtl/addr_scanner.sv | 130 +++++++++++++
 tb/tb_addr_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/addr_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addr_scanner_pkg
// Brief    : Mode encodings and scan-state type shared by the address scanner.
// Revision : 1.0
// ============================================================================
package addr_scanner_pkg;

  localparam logic [1:0] SCAN_RUN  = 2'd0;
  localparam logic [1:0] SCAN_HOLD = 2'd1;
  localparam logic [1:0] SCAN_STEP = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_STEP = 2'd2
  } scan_state_e;

  // The unused mode code 3 behaves as HOLD.
  function automatic scan_state_e mode_to_state(input logic [1:0] mode);
    scan_state_e st;
    case (mode)
      SCAN_RUN:  st = ST_RUN;
      SCAN_STEP: st = ST_STEP;
      default:   st = ST_HOLD;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_scanner_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : addr_scanner_tick_gen
// Brief    : Clock-enable prescaler with runtime slow/fast select and clear.
// Revision : 1.0
// ============================================================================
module addr_scanner_tick_gen
  import addr_scanner_pkg::*;
#(
  parameter int SLOW_DIV = 100_000_000,
  parameter int FAST_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_fast,
  output logic o_tick
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV);
  localparam logic [CNT_W-1:0] c_slow_last = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] c_fast_last = CNT_W'(FAST_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_hit;

  assign w_last = i_fast ? c_fast_last : c_slow_last;
  assign w_hit  = i_en & ~i_clr & (r_cnt == w_last);
  assign o_tick = w_hit;

  // Disabled or cleared holds the count at zero so a restart takes a full period.
  always_ff @(posedge clk) begin
    if (rst || !i_en || i_clr || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/addr_scanner.sv
`default_nettype none
// ============================================================================
// Module   : addr_scanner
// Brief    : Wrapping address sweep over [lo, hi] with run/hold/step modes.
// Revision : 1.0
// ============================================================================
module addr_scanner
  import addr_scanner_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int SLOW_DIV = 100_000_000,
  parameter int FAST_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              fast,
  input  logic              dir,
  input  logic              step_btn,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  output logic [ADDR_W-1:0] addr,
  output logic              adv,
  output logic              wrap
);

  scan_state_e       r_state;
  scan_state_e       w_state_nxt;
  logic              w_run_en;
  logic              w_step_en;
  logic              r_fast_q;
  logic              r_step_q;
  logic              w_tick;
  logic              w_step_req;
  logic              w_advance;
  logic              w_in_win;
  logic [ADDR_W-1:0] r_addr;
  logic              r_adv;
  logic              r_wrap;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_next_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= mode_to_state(mode);
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = mode_to_state(mode);
    w_run_en    = 1'b0;
    w_step_en   = 1'b0;
    case (r_state)
      ST_RUN:  w_run_en  = 1'b1;
      ST_STEP: w_step_en = 1'b1;
      default: ;
    endcase
  end

  addr_scanner_tick_gen #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run_en),
    .i_clr  (fast ^ r_fast_q),
    .i_fast (fast),
    .o_tick (w_tick)
  );

  assign w_step_req = step_btn & ~r_step_q;
  assign w_advance  = (w_run_en & w_tick) | (w_step_en & w_step_req);
  assign w_in_win   = (r_addr >= lo) && (r_addr <= hi);

  // An address outside the window re-enters at the bound the sweep heads from.
  always_comb begin
    w_next_addr = r_addr;
    w_next_wrap = 1'b0;
    if (!dir) begin
      if (!w_in_win || (r_addr == hi)) begin
        w_next_addr = lo;
        w_next_wrap = 1'b1;
      end else begin
        w_next_addr = r_addr + 1'b1;
      end
    end else begin
      if (!w_in_win || (r_addr == lo)) begin
        w_next_addr = hi;
        w_next_wrap = 1'b1;
      end else begin
        w_next_addr = r_addr - 1'b1;
      end
    end
  end

  // fast is captured at reset so the first period after reset is not cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= lo;
      r_adv    <= 1'b0;
      r_wrap   <= 1'b0;
      r_step_q <= 1'b0;
      r_fast_q <= fast;
    end else begin
      r_step_q <= step_btn;
      r_fast_q <= fast;
      if (lo > hi) begin
        r_addr <= lo;
        r_adv  <= (r_addr != lo);
        r_wrap <= 1'b0;
      end else if (w_advance) begin
        r_addr <= w_next_addr;
        r_adv  <= 1'b1;
        r_wrap <= w_next_wrap;
      end else begin
        r_adv  <= 1'b0;
        r_wrap <= 1'b0;
      end
    end
  end

  assign addr = r_addr;
  assign adv  = r_adv;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_addr_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_scanner
// Brief    : Scoreboard bench for addr_scanner with a behavioural reference.
// Revision : 1.0
// ============================================================================
module tb_addr_scanner;

  localparam int AW    = 5;
  localparam int SLOWD = 8;
  localparam int FASTD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          fast = 1'b0;
  logic          dir = 1'b0;
  logic          step_btn = 1'b0;
  logic [AW-1:0] lo = 5'd3;
  logic [AW-1:0] hi = 5'd6;
  logic [AW-1:0] addr;
  logic          adv;
  logic          wrap;

  addr_scanner #(.ADDR_W(AW), .SLOW_DIV(SLOWD), .FAST_DIV(FASTD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .fast(fast), .dir(dir),
    .step_btn(step_btn), .lo(lo), .hi(hi), .addr(addr), .adv(adv), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int adv_cnt  = 0;

  // Reference model: mode string, cycles elapsed in the current run period.
  logic [5:0]    sb[$];
  bit            m_live = 0;
  string         m_mode = "HOLD";
  int            m_elapsed = 0;
  bit            m_prev_btn = 0;
  bit            m_prev_fast = 0;
  logic [AW-1:0] m_addr;

  function automatic string mode_name(input logic [1:0] m);
    if (m == 2'd0) return "RUN";
    if (m == 2'd2) return "STEP";
    return "HOLD";
  endfunction

  always @(posedge clk) begin
    int  div;
    bit  fire;
    int  a;
    if (rst) begin
      m_live      = 1;
      m_addr      = lo;
      m_elapsed   = 0;
      m_prev_btn  = 0;
      m_prev_fast = fast;
      m_mode      = mode_name(mode);
    end else begin
      div  = fast ? FASTD : SLOWD;
      fire = 0;
      if (m_mode != "RUN" || fast != m_prev_fast) begin
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == div) begin
          fire = (m_mode == "RUN");
          m_elapsed = 0;
        end
      end
      if (m_mode == "STEP" && step_btn && !m_prev_btn) fire = 1;
      a = int'(m_addr);
      if (lo > hi) begin
        if (a != int'(lo)) sb.push_back({lo, 1'b0});
        m_addr = lo;
      end else if (fire) begin
        if (a < int'(lo) || a > int'(hi) || (!dir && a == int'(hi)) || (dir && a == int'(lo))) begin
          m_addr = dir ? hi : lo;
          sb.push_back({m_addr, 1'b1});
        end else begin
          m_addr = dir ? AW'(a - 1) : AW'(a + 1);
          sb.push_back({m_addr, 1'b0});
        end
      end
      m_prev_btn  = step_btn;
      m_prev_fast = fast;
      m_mode      = mode_name(mode);
    end
  end

  // Monitor: compares whenever the DUT presents an advance.
  always @(negedge clk) begin
    logic [5:0] e;
    if (m_live) begin
      n_checks++;
      if (addr !== m_addr) begin
        n_errors++;
        $display("FAIL addr_track t=%0t got %0d want %0d", $time, addr, m_addr);
      end
      n_checks++;
      if (adv === 1'b1) begin
        adv_cnt++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_adv t=%0t addr %0d wrap %0b want no adv", $time, addr, wrap);
        end else begin
          e = sb.pop_front();
          if ({addr, wrap} !== e) begin
            n_errors++;
            $display("FAIL adv_value t=%0t got addr %0d wrap %0b want addr %0d wrap %0b",
                     $time, addr, wrap, e[5:1], e[0]);
          end
        end
      end else begin
        if (sb.size() != 0 || wrap !== 1'b0) begin
          n_errors++;
          $display("FAIL missing_adv t=%0t adv %0b wrap %0b pending %0d want adv 1", $time, adv, wrap, sb.size());
          if (sb.size() != 0) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
    end
  endtask

  initial begin
    int c0;
    // Reset with [3,6], then slow run upward: 4,5,6,3 at 8-cycle spacing.
    rst = 1; lo = 5'd3; hi = 5'd6; mode = 2'd0; fast = 0; dir = 0;
    cyc(2);
    rst = 0;
    chk("reset_addr", addr, 3); chk("reset_adv", adv, 0); chk("reset_wrap", wrap, 0);
    cyc(7);  chk("first_adv_early", adv, 0);
    cyc(1);  chk("first_adv", adv, 1); chk("first_addr", addr, 4);
    cyc(24); chk("wrap_addr", addr, 3); chk("wrap_adv", adv, 1); chk("wrap_pulse", wrap, 1);

    // Reset mid-run; next period is a full 8 cycles from reset release.
    cyc(5); rst = 1; cyc(1);
    chk("midrst_addr", addr, 3); chk("midrst_adv", adv, 0);
    rst = 0; cyc(7); chk("midrst_early", adv, 0);
    cyc(1); chk("midrst_adv1", adv, 1); chk("midrst_addr1", addr, 4);

    // Fast down sweep over the full range, then a rate change mid-count.
    rst = 1; lo = 5'd0; hi = 5'd31; dir = 1; fast = 1; cyc(1); rst = 0;
    chk("fast_reset_addr", addr, 0);
    cyc(1); chk("fast_adv_early", adv, 0);
    cyc(1); chk("fast_wrap_addr", addr, 31); chk("fast_wrap", wrap, 1);
    cyc(2); chk("fast_addr30", addr, 30); chk("fast_adv30", adv, 1);
    cyc(1); fast = 0;
    cyc(8); chk("rate_chg_early", adv, 0);
    cyc(1); chk("rate_chg_adv", adv, 1); chk("rate_chg_addr", addr, 29);

    // STEP: held button gives one advance per rising edge.
    lo = 5'd3; hi = 5'd6; dir = 0; mode = 2'd2; cyc(2);
    c0 = adv_cnt;
    step_btn = 1; cyc(5); step_btn = 0; cyc(3); step_btn = 1; cyc(3); step_btn = 0; cyc(2);
    chk("step_count", adv_cnt - c0, 2);

    // HOLD ignores button edges.
    mode = 2'd1; cyc(2);
    c0 = adv_cnt;
    repeat (3) begin step_btn = 1; cyc(2); step_btn = 0; cyc(2); end
    chk("hold_count", adv_cnt - c0, 0);

    // Bounds moved away from the current address, then a degenerate window.
    rst = 1; lo = 5'd10; hi = 5'd20; mode = 2'd1; fast = 0; cyc(1); rst = 0;
    chk("bnd_reset_addr", addr, 10);
    lo = 5'd12; hi = 5'd15; mode = 2'd0; dir = 0;
    cyc(8); chk("bnd_early", adv, 0);
    cyc(1); chk("bnd_addr", addr, 12); chk("bnd_wrap", wrap, 1);
    lo = 5'd9; hi = 5'd4;
    cyc(1); chk("degen_addr", addr, 9); chk("degen_adv", adv, 1); chk("degen_wrap", wrap, 0);
    cyc(1); chk("degen_stable_addr", addr, 9); chk("degen_stable_adv", adv, 0);

    // Randomised traffic, model-checked by the monitor.
    lo = 5'd2; hi = 5'd9;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) fast = ~fast;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 79) == 0) begin
        lo = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 4) == 0) hi = 5'($urandom_range(0, 31));
        else hi = 5'($urandom_range(int'(lo), 31));
      end
      cyc(1);
    end
    rst = 0; mode = 2'd1;
    cyc(3);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
